// File: rtl/vga_pkg.sv
// Shared VGA timing constants, divider mode encodings and controller state enumeration.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package vga_pkg;

    // Default 640x480@60 raster timing, in pixels and lines
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // Frequency divider MODE encodings
    localparam logic MODE_DIV2 = 1'b0;
    localparam logic MODE_DIV1 = 1'b1;

    // Mode-switch controller states
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PEND   = 2'd1,
        SWITCH = 2'd2
    } vga_state_e;

    // True when counter value v lies in the inclusive range [lo, hi]
    function automatic logic in_span(input logic [9:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

endpackage

// File: rtl/vga_raster_cnt.sv
// Raster X/Y counters: X wraps at H_TOTAL and carries into Y, which wraps at V_TOTAL.
// Latency: x/y update on the CLK edge that samples adv; x_nxt/y_nxt are the combinational next values.
// Backpressure: none; counters move only when adv is high, clr forces both to zero.
module vga_raster_cnt #(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       adv,
    input  logic       clr,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [9:0] x_nxt,
    output logic [9:0] y_nxt,
    output logic       at_last
);

    localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;

    // Next counter values: clear wins, otherwise advance with line/frame wrap
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (adv) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign x_nxt   = x_d;
    assign y_nxt   = y_d;
    assign at_last = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator with divider mode switching deferred to the frame boundary, then a blanked settle window.
// Latency: sync/DE/X/Y registered and mutually aligned (no added latency); MODE_ACK one CLK after a same-mode request or after settle.
// Backpressure: none; raster advances only on PIX_EN, new MODE_REQs ignored while a switch is pending or settling.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to add the 16-bit FRAME_CNT output.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter int SYNC_POL   = 0,
    parameter int SETTLE_CYC = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PIX_EN,
    input  logic        MODE_REQ,
    input  logic        MODE_SEL,
    output logic        MODE_ACK,
    output logic        DIV_MODE,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        DE,
    output logic [9:0]  X,
    output logic [9:0]  Y,
    output logic        FRAME_START
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] FRAME_CNT
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC - 1;

    // SYNC_POL = 0 means pulses drive low
    localparam logic SYNC_ASSERT = (SYNC_POL != 0);
    localparam logic SYNC_IDLE   = ~SYNC_ASSERT;

    localparam int             SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE_CYC - 1);

    vga_state_e    state_q, state_d;
    logic          div_mode_q, div_mode_d;
    logic          pend_sel_q, pend_sel_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          mode_ack_q, mode_ack_d;
    logic          frame_start_q, frame_start_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic          blank_d;

    logic          adv, clr, at_last;
    logic [9:0]    x_nxt, y_nxt;

    vga_raster_cnt #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_raster (
        .clk     (CLK),
        .rst_n   (RST),
        .adv     (adv),
        .clr     (clr),
        .x       (X),
        .y       (Y),
        .x_nxt   (x_nxt),
        .y_nxt   (y_nxt),
        .at_last (at_last)
    );

    // Mode-switch FSM: next state, divider mode, settle timer, ack and frame-start pulses
    always_comb begin
        state_d    = state_q;
        div_mode_d = div_mode_q;
        pend_sel_d = pend_sel_q;
        settle_d   = settle_q;
        mode_ack_d = 1'b0;
        adv        = 1'b0;
        clr        = 1'b0;
        case (state_q)
            RUN: begin
                adv = PIX_EN;
                if (MODE_REQ) begin
                    if (MODE_SEL == div_mode_q) begin
                        mode_ack_d = 1'b1;
                    end else begin
                        pend_sel_d = MODE_SEL;
                        state_d    = PEND;
                    end
                end
            end
            PEND: begin
                adv = PIX_EN;
                // Divider changes only as the last pixel of the frame is consumed
                if (PIX_EN && at_last) begin
                    div_mode_d = pend_sel_q;
                    settle_d   = '0;
                    state_d    = SWITCH;
                end
            end
            SWITCH: begin
                // Raster parked at origin while the divider output settles
                clr = 1'b1;
                if (settle_q == SETTLE_LAST) begin
                    state_d    = RUN;
                    mode_ack_d = 1'b1;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        frame_start_d = adv && (X == '0) && (Y == '0);
    end

    // Sync and DE decode from the next counter values so they line up with X/Y
    always_comb begin
        blank_d = (state_d == SWITCH);
        hsync_d = SYNC_IDLE;
        vsync_d = SYNC_IDLE;
        de_d    = 1'b0;
        if (!blank_d) begin
            if (in_span(x_nxt, HS_BEG, HS_END)) hsync_d = SYNC_ASSERT;
            if (in_span(y_nxt, VS_BEG, VS_END)) vsync_d = SYNC_ASSERT;
            de_d = (int'(x_nxt) < H_ACTIVE) && (int'(y_nxt) < V_ACTIVE);
        end
    end

    // State and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= RUN;
            div_mode_q    <= MODE_DIV2;
            pend_sel_q    <= MODE_DIV2;
            settle_q      <= '0;
            mode_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
            hsync_q       <= SYNC_IDLE;
            vsync_q       <= SYNC_IDLE;
            de_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_mode_q    <= div_mode_d;
            pend_sel_q    <= pend_sel_d;
            settle_q      <= settle_d;
            mode_ack_q    <= mode_ack_d;
            frame_start_q <= frame_start_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
        end
    end

    assign MODE_ACK    = mode_ack_q;
    assign DIV_MODE    = div_mode_q;
    assign HSYNC       = hsync_q;
    assign VSYNC       = vsync_q;
    assign DE          = de_q;
    assign FRAME_START = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Frame counter advances with each frame start and naturally wraps at 16 bits
    always_comb begin
        frame_cnt_d = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    // Frame counter register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign FRAME_CNT = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench for vga_timing_ctrl: random pixel strobes and mode requests against a pixel-index reference model.
// Latency: model predicts the registered outputs visible after each CLK edge.
// Backpressure: requester holds MODE_REQ until MODE_ACK, dropped on reset.
module tb_vga_timing_ctrl;

    // Full-width lines, short frames so several frame boundaries fit in the run
    localparam int H_ACTIVE  = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int V_ACTIVE  = 4;
    localparam int V_FP      = 1;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 1;
    localparam int SETTLE    = 4;
    localparam int H_TOT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME_PIX = H_TOT * V_TOT;

    logic       CLK = 1'b0;
    logic       RST;
    logic       PIX_EN;
    logic       MODE_REQ;
    logic       MODE_SEL;
    logic       MODE_ACK;
    logic       DIV_MODE;
    logic       HSYNC;
    logic       VSYNC;
    logic       DE;
    logic [9:0] X;
    logic [9:0] Y;
    logic       FRAME_START;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] FRAME_CNT;
`endif

    vga_timing_ctrl #(
        .H_ACTIVE   (H_ACTIVE),
        .H_FP       (H_FP),
        .H_SYNC     (H_SYNC),
        .H_BP       (H_BP),
        .V_ACTIVE   (V_ACTIVE),
        .V_FP       (V_FP),
        .V_SYNC     (V_SYNC),
        .V_BP       (V_BP),
        .SYNC_POL   (0),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .PIX_EN      (PIX_EN),
        .MODE_REQ    (MODE_REQ),
        .MODE_SEL    (MODE_SEL),
        .MODE_ACK    (MODE_ACK),
        .DIV_MODE    (DIV_MODE),
        .HSYNC       (HSYNC),
        .VSYNC       (VSYNC),
        .DE          (DE),
        .X           (X),
        .Y           (Y),
        .FRAME_START (FRAME_START)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .FRAME_CNT   (FRAME_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: linear pixel index within the frame plus mode bookkeeping
    int   m_pix;
    int   m_settle;
    logic m_mode;
    logic m_pend;
    logic m_pend_sel;
    logic e_ack;
    logic e_fs;
    int   m_frames;
    int   exp_acks;
    int   exp_fs;
    int   ack_seen;
    int   fs_seen;

    // Requester state
    logic req_on;
    logic req_sel;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pix      = 0;
        m_settle   = 0;
        m_mode     = 1'b0;
        m_pend     = 1'b0;
        m_pend_sel = 1'b0;
        e_ack      = 1'b0;
        e_fs       = 1'b0;
        m_frames   = 0;
    endtask

    // Advance the model by one CLK edge given the inputs sampled at that edge
    task automatic model_step(input logic pe, input logic rq, input logic sl);
        logic was_pend;
        e_ack = 1'b0;
        e_fs  = 1'b0;
        if (m_settle > 0) begin
            m_settle--;
            if (m_settle == 0) e_ack = 1'b1;
        end else begin
            was_pend = m_pend;
            if (pe) begin
                if (m_pix == 0) begin
                    e_fs = 1'b1;
                    m_frames++;
                end
                if (was_pend && m_pix == FRAME_PIX - 1) begin
                    m_mode   = m_pend_sel;
                    m_pend   = 1'b0;
                    m_settle = SETTLE;
                end
                m_pix = (m_pix + 1) % FRAME_PIX;
            end
            if (!was_pend && rq) begin
                if (sl == m_mode) begin
                    e_ack = 1'b1;
                end else begin
                    m_pend     = 1'b1;
                    m_pend_sel = sl;
                end
            end
        end
        if (e_ack) exp_acks++;
        if (e_fs)  exp_fs++;
    endtask

    task automatic check_outputs();
        int   ex;
        int   ey;
        logic blank;
        ex    = m_pix % H_TOT;
        ey    = m_pix / H_TOT;
        blank = (m_settle > 0);
        chk("X", int'(X), ex);
        chk("Y", int'(Y), ey);
        chk("HSYNC", int'(HSYNC), (!blank && ex >= H_ACTIVE + H_FP && ex < H_ACTIVE + H_FP + H_SYNC) ? 0 : 1);
        chk("VSYNC", int'(VSYNC), (!blank && ey >= V_ACTIVE + V_FP && ey < V_ACTIVE + V_FP + V_SYNC) ? 0 : 1);
        chk("DE", int'(DE), (!blank && ex < H_ACTIVE && ey < V_ACTIVE) ? 1 : 0);
        chk("MODE_ACK", int'(MODE_ACK), int'(e_ack));
        chk("FRAME_START", int'(FRAME_START), int'(e_fs));
        chk("DIV_MODE", int'(DIV_MODE), int'(m_mode));
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("FRAME_CNT", int'(FRAME_CNT), m_frames % 65536);
`endif
    endtask

    task automatic check_reset();
        chk("rst_X", int'(X), 0);
        chk("rst_Y", int'(Y), 0);
        chk("rst_HSYNC", int'(HSYNC), 1);
        chk("rst_VSYNC", int'(VSYNC), 1);
        chk("rst_DE", int'(DE), 0);
        chk("rst_MODE_ACK", int'(MODE_ACK), 0);
        chk("rst_FRAME_START", int'(FRAME_START), 0);
        chk("rst_DIV_MODE", int'(DIV_MODE), 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("rst_FRAME_CNT", int'(FRAME_CNT), 0);
`endif
    endtask

    // One CLK: drive inputs, step the model at the edge, check on the falling edge
    task automatic cycle(input logic pe);
        PIX_EN   = pe;
        MODE_REQ = req_on;
        MODE_SEL = req_sel;
        @(posedge CLK);
        if (RST) model_step(pe, req_on, req_sel);
        else     model_reset();
        @(negedge CLK);
        if (RST) check_outputs();
        else     check_reset();
        if (MODE_ACK)    ack_seen++;
        if (FRAME_START) fs_seen++;
        if (MODE_ACK) begin
            // Usually drop on ack; occasionally linger a cycle, which counts as a new request
            if ($urandom_range(0, 3) != 0) req_on = 1'b0;
        end else if (req_on && $urandom_range(0, 15) == 0) begin
            // Flipping the selection while a switch is in flight must be ignored
            req_sel = ~req_sel;
        end
    endtask

    initial begin
        bit reached;
        exp_acks = 0;
        exp_fs   = 0;
        ack_seen = 0;
        fs_seen  = 0;
        req_on   = 1'b0;
        req_sel  = 1'b0;
        PIX_EN   = 1'b0;
        MODE_REQ = 1'b0;
        MODE_SEL = 1'b0;
        model_reset();

        // Reset held: outputs at reset values
        RST = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) cycle(1'b1);
        RST = 1'b1;

        // PIX_EN every 2nd CLK; request /1 during line 2 of the first frame
        for (int i = 0; i < 2 * FRAME_PIX + 40; i++) begin
            if (!req_on && !m_pend && m_settle == 0 && m_mode == 1'b0 && (m_pix / H_TOT) == 2) begin
                req_on  = 1'b1;
                req_sel = 1'b1;
            end
            cycle(i[0]);
        end
        chk("div1_after_switch", int'(DIV_MODE), 1);

        // Same-mode request while idle: ack next cycle, raster untouched
        req_on = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0);
        req_on  = 1'b1;
        req_sel = m_mode;
        cycle(1'b0);
        req_on = 1'b0;
        cycle(1'b0);

        // Random strobes and random requests
        for (int i = 0; i < 30000; i++) begin
            if (!req_on && $urandom_range(0, 2999) == 0) begin
                req_on  = 1'b1;
                req_sel = 1'($urandom_range(0, 1));
            end
            cycle($urandom_range(0, 3) != 0);
        end

        // Drive a switch and pull reset in the middle of the settle window
        req_on = 1'b0;
        while (m_settle != 0 || m_pend || MODE_ACK) cycle(1'b1);
        req_on  = 1'b1;
        req_sel = ~m_mode;
        reached = 1'b0;
        for (int i = 0; i < 3 * FRAME_PIX && !reached; i++) begin
            cycle($urandom_range(0, 3) != 0);
            if (m_settle == 2) reached = 1'b1;
        end
        chk("switch_reached", int'(reached), 1);
        RST    = 1'b0;
        req_on = 1'b0;
        #1;
        chk("rst_mid_switch_div", int'(DIV_MODE), 0);
        chk("rst_mid_switch_ack", int'(MODE_ACK), 0);
        for (int i = 0; i < 3; i++) cycle($urandom_range(0, 1) != 0);
        RST = 1'b1;
        for (int i = 0; i < 2000; i++) cycle($urandom_range(0, 1) != 0);

        chk("ack_count", ack_seen, exp_acks);
        chk("frame_start_count", fs_seen, exp_fs);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameters SHALL be: H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, SYNC_POL 0 (0 = sync pulses active-low), SETTLE_CYC 4 (CLK cycles blanked after a divider mode switch).
REQ-002 CLK  in  1  system clock; the only clock.
REQ-003 RST  in  1  asynchronous, active-low reset.
REQ-004 PIX_EN  in  1  one-CLK pixel strobe from the frequency divider; all raster advancement is qualified by it.
REQ-005 MODE_REQ  in  1  mode-change request, level.
REQ-006 MODE_SEL  in  1  requested divider mode (0 = /2, 1 = /1).
REQ-007 MODE_ACK  out  1  one-CLK pulse when the requested mode is active.
REQ-008 DIV_MODE  out  1  MODE input to the frequency divider.
REQ-009 HSYNC, VSYNC  out  1 each  sync outputs, polarity per SYNC_POL.
REQ-010 DE  out  1  high in the active area only.
REQ-011 X, Y  out  10 each  current pixel column and line.
REQ-012 FRAME_START  out  1  one-CLK pulse on the PIX_EN that begins X=0,Y=0.

Function
REQ-013 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525); X and Y SHALL be the raw counters.
REQ-014 X SHALL increment on each PIX_EN, wrapping H_TOTAL-1 -> 0; Y SHALL increment on that wrap, wrapping V_TOTAL-1 -> 0; no change without PIX_EN.
REQ-015 Outputs SHALL be registered and reflect the current X/Y in the same cycle as the counters (zero added latency).
REQ-016 HSYNC SHALL be asserted for X in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; VSYNC likewise for Y over the V ranges.
REQ-017 DE SHALL be high when X<H_ACTIVE and Y<V_ACTIVE, and forced low in SWITCH.
REQ-018 FSM states SHALL be RUN, PEND, SWITCH.
REQ-019 RUN: MODE_REQ with MODE_SEL == DIV_MODE -> MODE_ACK pulse next cycle, stay RUN; MODE_REQ with MODE_SEL != DIV_MODE -> latch MODE_SEL, go PEND.
REQ-020 PEND: on PIX_EN at X=H_TOTAL-1, Y=V_TOTAL-1 -> DIV_MODE takes latched value, X=Y=0, go SWITCH; MODE_REQ/MODE_SEL ignored in PEND and SWITCH.
REQ-021 SWITCH: counters held at 0, HSYNC/VSYNC deasserted, PIX_EN ignored for SETTLE_CYC CLK cycles; then MODE_ACK pulse, FRAME_START pulses on the next PIX_EN, go RUN.
REQ-022 MODE_REQ still high after MODE_ACK SHALL be treated as a new request (requesters drop REQ on ACK).

Reset
REQ-023 While RST low: X=0, Y=0, state RUN, DIV_MODE=0, DE=0, MODE_ACK=0, FRAME_START=0, HSYNC/VSYNC deasserted.
REQ-024 Reset mid-PEND or mid-SWITCH SHALL abandon the request without issuing MODE_ACK.
REQ-025 The first PIX_EN after reset release SHALL produce FRAME_START.

Configuration
REQ-026 Macro VGA_TIMING_FRAME_CNT_EN: when defined, output FRAME_CNT [15:0] SHALL increment on each FRAME_START, wrap 65535 -> 0, reset 0, and hold through SWITCH; when undefined, the port and counter SHALL be absent with all other behaviour unchanged.

Structure
REQ-027 Shared package vga_pkg SHALL hold the timing constants, mode encodings (MODE_DIV2 = 0, MODE_DIV1 = 1) and the FSM state enumeration.
REQ-028 Sub-module vga_raster_cnt (X/Y counters, wrap, hold, clear) is natural; FSM and sync decode stay in the top level.

Verification
REQ-029 PIX_EN every 2nd CLK, 800 PIX_EN: HSYNC low exactly for X=656..751 (96 strobes), DE high for X=0..639 on Y=0.
REQ-030 Full frame: VSYNC low for Y=490..491, FRAME_START once per 420000 PIX_EN, Y wraps 524 -> 0.
REQ-031 MODE_REQ, MODE_SEL=1 at Y=100: DIV_MODE stays 0 until last pixel (799,524), then 1; 4 blank cycles; MODE_ACK one pulse; FRAME_START on next PIX_EN.
REQ-032 MODE_REQ, MODE_SEL=0 while DIV_MODE=0: MODE_ACK next cycle, counters undisturbed.
REQ-033 RST low during SWITCH: all outputs at reset values, no MODE_ACK, DIV_MODE=0.
REQ-034 With VGA_TIMING_FRAME_CNT_EN: preload FRAME_CNT to 65535 by 65535 frames (or force), next FRAME_START -> 0.
